// File: rtl/commit_trace_buf.sv
// Circular capture buffer for commit/trap events with sequence tagging,
// overflow policy, trap-only filtering and freeze-on-trap; drained via valid/ready.
module commit_trace_buf #(
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned GPR_AW    = 3,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned SEQ_W     = 16,
    parameter int unsigned OVERWRITE = 0,
    parameter int unsigned ENTRY_W   = 3*WORD_W+GPR_AW+9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     c_valid,
    input  logic [ENTRY_W-1:0]       c_entry,
    input  logic                     cfg_trap_only,
    input  logic                     cfg_freeze_on_trap,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ENTRY_W-1:0]       out_entry,
    output logic [SEQ_W-1:0]         out_seq,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              drop_cnt,
    output logic                     frozen
);

    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned TRAP_BIT = ENTRY_W - 1;

    logic [ENTRY_W-1:0] mem_entry [DEPTH];
    logic [SEQ_W-1:0]   mem_seq   [DEPTH];

    logic [PTR_W-1:0] wptr, wptr_n, rptr, rptr_n;
    logic [CNT_W-1:0] count_n;
    logic [15:0]      drop_cnt_n;
    logic [SEQ_W-1:0] seq, seq_n;
    logic             frozen_n;

    logic is_trap_c, event_c, eligible_c, full_c, pop_c;
    logic push_c, overwrite_c, drop_c, wr_en_c;

    assign out_valid = (count != '0);
    assign out_entry = out_valid ? mem_entry[rptr] : '0;
    assign out_seq   = out_valid ? mem_seq[rptr]   : '0;

    // Event qualification and push/pop/drop decisions
    always_comb begin
        is_trap_c   = c_entry[TRAP_BIT];
        event_c     = c_valid && !frozen;
        eligible_c  = event_c && (!cfg_trap_only || is_trap_c);
        full_c      = (count == CNT_W'(DEPTH));
        pop_c       = out_valid && out_ready;
        push_c      = eligible_c && (!full_c || pop_c);
        drop_c      = eligible_c && full_c && !pop_c;
        overwrite_c = drop_c && (OVERWRITE != 0);
        wr_en_c     = !clear && (push_c || overwrite_c);
    end

    // Next-state for pointers, occupancy, counters and freeze
    always_comb begin
        wptr_n     = wptr;
        rptr_n     = rptr;
        count_n    = count;
        drop_cnt_n = drop_cnt;
        seq_n      = seq;
        frozen_n   = frozen;
        if (clear) begin
            wptr_n     = '0;
            rptr_n     = '0;
            count_n    = '0;
            drop_cnt_n = '0;
            seq_n      = '0;
            frozen_n   = 1'b0;
        end else begin
            if (push_c || overwrite_c)
                wptr_n = wptr + PTR_W'(1);
            if (pop_c || overwrite_c)
                rptr_n = rptr + PTR_W'(1);
            if (push_c && !pop_c)
                count_n = count + CNT_W'(1);
            else if (pop_c && !push_c)
                count_n = count - CNT_W'(1);
            if (drop_c && (drop_cnt != 16'hFFFF))
                drop_cnt_n = drop_cnt + 16'd1;
            if (event_c)
                seq_n = seq + SEQ_W'(1);
            // A freezing trap sets frozen even if the buffer had to drop it
            if (eligible_c && is_trap_c && cfg_freeze_on_trap)
                frozen_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            drop_cnt <= '0;
            seq      <= '0;
            frozen   <= 1'b0;
        end else begin
            wptr     <= wptr_n;
            rptr     <= rptr_n;
            count    <= count_n;
            drop_cnt <= drop_cnt_n;
            seq      <= seq_n;
            frozen   <= frozen_n;
        end
    end

    // Storage needs no reset: out_* are masked while empty
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_entry[wptr] <= c_entry;
            mem_seq[wptr]   <= seq;
        end
    end

endmodule

// File: tb/tb_commit_trace_buf.sv
// Self-checking bench: drop-newest and overwrite-oldest instances share stimulus;
// a queue-based model predicts each drained entry.
module tb_commit_trace_buf;

    localparam int EW = 3*16+3+9;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [15:0]   seq;
        logic [EW-1:0] e;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          c_valid;
    logic [EW-1:0] c_entry;
    logic          cfg_trap_only;
    logic          cfg_freeze_on_trap;
    logic          clear;
    logic          out_ready;

    logic          ov0, ov1;
    logic [EW-1:0] oe0, oe1;
    logic [15:0]   os0, os1;
    logic [4:0]    cnt0, cnt1;
    logic [15:0]   dc0, dc1;
    logic          fz0, fz1;

    int checks = 0;
    int failures = 0;

    exp_t q0[$];
    exp_t q1[$];
    int   m_seq = 0;
    bit   m_frozen = 0;
    int   m_drop0 = 0;
    int   m_drop1 = 0;

    always #5 clk = ~clk;

    commit_trace_buf #(.OVERWRITE(0)) dut0 (
        .clk(clk), .rst(rst), .c_valid(c_valid), .c_entry(c_entry),
        .cfg_trap_only(cfg_trap_only), .cfg_freeze_on_trap(cfg_freeze_on_trap),
        .clear(clear), .out_valid(ov0), .out_ready(out_ready), .out_entry(oe0),
        .out_seq(os0), .count(cnt0), .drop_cnt(dc0), .frozen(fz0)
    );

    commit_trace_buf #(.OVERWRITE(1)) dut1 (
        .clk(clk), .rst(rst), .c_valid(c_valid), .c_entry(c_entry),
        .cfg_trap_only(cfg_trap_only), .cfg_freeze_on_trap(cfg_freeze_on_trap),
        .clear(clear), .out_valid(ov1), .out_ready(out_ready), .out_entry(oe1),
        .out_seq(os1), .count(cnt1), .drop_cnt(dc1), .frozen(fz1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [EW-1:0] mk(input bit trap, input logic [3:0] code, input logic [15:0] pc);
        logic [15:0] pa, wd;
        pa = pc + 16'd1;
        wd = pc * 16'd3;
        return {trap, code, pc, pa, 1'b1, pc[2:0], wd, 3'b101};
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_seq = 0;
        m_frozen = 0;
        m_drop0 = 0;
        m_drop1 = 0;
    endtask

    // One cycle: drive, compare heads being popped, update the model, clock.
    task automatic step(input bit v, input logic [EW-1:0] e, input bit rdy, input bit clr);
        exp_t it;
        c_valid = v;
        c_entry = e;
        out_ready = rdy;
        clear = clr;
        #1;
        chk("valid0", 64'(ov0), 64'(q0.size() > 0));
        chk("valid1", 64'(ov1), 64'(q1.size() > 0));
        if (clr) begin
            model_reset();
        end else begin
            if (rdy && q0.size() > 0) begin
                chk("entry0", 64'(oe0), 64'(q0[0].e));
                chk("seq0", 64'(os0), 64'(q0[0].seq));
                void'(q0.pop_front());
            end
            if (rdy && q1.size() > 0) begin
                chk("entry1", 64'(oe1), 64'(q1[0].e));
                chk("seq1", 64'(os1), 64'(q1[0].seq));
                void'(q1.pop_front());
            end
            if (v && !m_frozen) begin
                if (!cfg_trap_only || e[EW-1]) begin
                    it.seq = 16'(m_seq);
                    it.e = e;
                    if (q0.size() < DEPTH) q0.push_back(it);
                    else m_drop0++;
                    if (q1.size() == DEPTH) begin
                        void'(q1.pop_front());
                        m_drop1++;
                    end
                    q1.push_back(it);
                    if (e[EW-1] && cfg_freeze_on_trap) m_frozen = 1;
                end
                m_seq++;
            end
        end
        @(posedge clk);
        #1;
        c_valid = 1'b0;
        out_ready = 1'b0;
        clear = 1'b0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_count0"}, 64'(cnt0), 64'(q0.size()));
        chk({tag, "_count1"}, 64'(cnt1), 64'(q1.size()));
        chk({tag, "_drop0"}, 64'(dc0), 64'(m_drop0));
        chk({tag, "_drop1"}, 64'(dc1), 64'(m_drop1));
        chk({tag, "_frozen0"}, 64'(fz0), 64'(m_frozen));
        chk({tag, "_frozen1"}, 64'(fz1), 64'(m_frozen));
    endtask

    initial begin
        rst = 1'b1;
        c_valid = 1'b0;
        c_entry = '0;
        cfg_trap_only = 1'b0;
        cfg_freeze_on_trap = 1'b0;
        clear = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values
        chk("rst_valid", 64'(ov0), 64'd0);
        chk("rst_entry", 64'(oe0), 64'd0);
        chk("rst_seq", 64'(os0), 64'd0);
        chk("rst_count", 64'(cnt0), 64'd0);
        chk("rst_drop", 64'(dc1), 64'd0);
        chk("rst_frozen", 64'(fz1), 64'd0);

        // Three commits held, then drained in order
        for (int i = 0; i < 3; i++) step(1'b1, mk(1'b0, 4'd0, 16'(i)), 1'b0, 1'b0);
        chk("basic_count", 64'(cnt0), 64'd3);
        chk_state("basic");
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk_state("basic_drained");

        // Overflow: 20 commits into 16 slots
        for (int i = 0; i < 20; i++) step(1'b1, mk(1'b0, 4'd0, 16'(100 + i)), 1'b0, 1'b0);
        chk("ovf_count0", 64'(cnt0), 64'd16);
        chk("ovf_drop0", 64'(dc0), 64'd4);
        chk("ovf_drop1", 64'(dc1), 64'd4);
        chk_state("ovf");

        // Full with simultaneous push and pop: no drops, seq keeps advancing
        for (int i = 0; i < 5; i++) step(1'b1, mk(1'b0, 4'd0, 16'(200 + i)), 1'b1, 1'b0);
        chk("fullpp_count1", 64'(cnt1), 64'd16);
        chk("fullpp_drop0", 64'(dc0), 64'd4);
        chk_state("fullpp");
        for (int i = 0; i < 17; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk_state("fullpp_drained");

        // Trap-only filter; seq still counts filtered commits
        step(1'b0, '0, 1'b0, 1'b1);
        cfg_trap_only = 1'b1;
        step(1'b1, mk(1'b0, 4'd0, 16'h300), 1'b0, 1'b0);
        step(1'b1, mk(1'b1, 4'd1, 16'h301), 1'b0, 1'b0);
        step(1'b1, mk(1'b0, 4'd0, 16'h302), 1'b0, 1'b0);
        step(1'b1, mk(1'b1, 4'd2, 16'h303), 1'b0, 1'b0);
        chk("trap_only_count", 64'(cnt0), 64'd2);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk_state("trap_only");
        cfg_trap_only = 1'b0;

        // Freeze on first captured trap, then clear (with a colliding event)
        step(1'b0, '0, 1'b0, 1'b1);
        cfg_freeze_on_trap = 1'b1;
        step(1'b1, mk(1'b0, 4'd0, 16'h400), 1'b0, 1'b0);
        step(1'b1, mk(1'b1, 4'd5, 16'h401), 1'b0, 1'b0);
        step(1'b1, mk(1'b0, 4'd0, 16'h402), 1'b0, 1'b0);
        step(1'b1, mk(1'b0, 4'd0, 16'h403), 1'b0, 1'b0);
        chk("freeze_frozen", 64'(fz0), 64'd1);
        chk("freeze_count", 64'(cnt1), 64'd2);
        chk_state("freeze");
        step(1'b1, mk(1'b0, 4'd0, 16'h404), 1'b0, 1'b1);
        chk("clear_frozen", 64'(fz0), 64'd0);
        chk("clear_count", 64'(cnt0), 64'd0);
        cfg_freeze_on_trap = 1'b0;
        step(1'b1, mk(1'b0, 4'd0, 16'h405), 1'b0, 1'b0);
        chk_state("post_clear");
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Async reset mid-drain discards everything immediately
        for (int i = 0; i < 4; i++) step(1'b1, mk(1'b0, 4'd0, 16'(16'h500 + 16'(i))), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(ov0), 64'd0);
        chk("arst_count", 64'(cnt1), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, mk(1'b1, 4'd7, 16'h600), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk_state("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
